// File: rtl/ysyx_22050710_md_pkg.sv
// Shared constants, FSM state type and word-mode helper for the M-extension execute unit.
package ysyx_22050710_md_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    function automatic logic [63:0] sext_word(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050710_md_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module ysyx_22050710_md_iter #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned CW   = $clog2(XLEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                step,
    input  logic                mode_div,
    input  logic [CW-1:0]       n,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                done_c,
    output logic [2*XLEN-1:0]   acc_nxt_c
);
    localparam int unsigned AW = 2 * XLEN + 1;

    logic [AW-1:0]   acc_q, acc_d, acc_step;
    logic [XLEN-1:0] b_q, b_d;
    logic            div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   sum;
    logic [XLEN+1:0] trial;

    // Multiply: {hi, lo} with lo holding the multiplier; divide: {rem, quotient/dividend}.
    always_comb begin
        sum   = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, b_q} : '0);
        trial = {1'b0, acc_q[AW-2:XLEN-1]} - {2'b00, b_q};
        if (!div_q) begin
            acc_step = {1'b0, sum, acc_q[XLEN-1:1]};
        end else if (trial[XLEN+1]) begin
            acc_step = {acc_q[AW-2:0], 1'b0};
        end else begin
            acc_step = {trial[XLEN:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (start) begin
            acc_d = {{(XLEN+1){1'b0}}, a};
            b_d   = b;
            div_d = mode_div;
            cnt_d = n;
        end else if (step) begin
            acc_d = acc_step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    // The final step's result is handed out combinationally so the caller can register it at once.
    assign done_c    = step && (cnt_q == CW'(1));
    assign acc_nxt_c = acc_step[AW-2:0];

endmodule

// File: rtl/ysyx_22050710_exu_md.sv
// Multi-cycle RISC-V M-extension unit: handshakes, special divide cases, sign handling and result select.
module ysyx_22050710_exu_md
    import ysyx_22050710_md_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned WORD_OPS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);
    localparam int unsigned CW = $clog2(XLEN + 1);

    function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] v);
        return w ? XLEN'(sext_word(v[31:0])) : v;
    endfunction

    md_state_e       state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            word_c, a_msb_c, b_msb_c, sgn_a_c, sgn_b_c, a_neg_c, b_neg_c;
    logic            div_zero_c, div_ovf_c, special_c, accept_c, start_c;
    logic [2:0]      op_eff_c;
    logic [XLEN-1:0] mask_c, min_c, a_n_c, b_n_c, mag_a_c, mag_b_c, a_load_c, spec_raw_c;
    logic [CW-1:0]   n_c;

    // Request decode: N-bit operand view, signedness, magnitudes and the no-iteration divide cases.
    always_comb begin
        word_c     = (WORD_OPS != 0) && (XLEN == 64) && i_word;
        op_eff_c   = (word_c && !i_op[2]) ? OP_MUL : i_op;
        mask_c     = word_c ? XLEN'(64'h0000_0000_FFFF_FFFF) : '1;
        min_c      = word_c ? XLEN'(64'h0000_0000_8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        a_n_c      = i_rs1 & mask_c;
        b_n_c      = i_rs2 & mask_c;
        a_msb_c    = word_c ? i_rs1[31] : i_rs1[XLEN-1];
        b_msb_c    = word_c ? i_rs2[31] : i_rs2[XLEN-1];
        sgn_a_c    = (op_eff_c != OP_MULHU) && (op_eff_c != OP_DIVU) && (op_eff_c != OP_REMU);
        sgn_b_c    = sgn_a_c && (op_eff_c != OP_MULHSU);
        a_neg_c    = sgn_a_c && a_msb_c;
        b_neg_c    = sgn_b_c && b_msb_c;
        mag_a_c    = a_neg_c ? ((~a_n_c + XLEN'(1)) & mask_c) : a_n_c;
        mag_b_c    = b_neg_c ? ((~b_n_c + XLEN'(1)) & mask_c) : b_n_c;
        a_load_c   = (op_eff_c[2] && word_c) ? (mag_a_c << 32) : mag_a_c;
        n_c        = word_c ? CW'(32) : CW'(XLEN);
        div_zero_c = op_eff_c[2] && (b_n_c == '0);
        div_ovf_c  = op_eff_c[2] && !op_eff_c[0] && (a_n_c == min_c) && (b_n_c == mask_c);
        special_c  = div_zero_c || div_ovf_c;
        if (div_zero_c) begin
            spec_raw_c = op_eff_c[1] ? i_rs1 : '1;
        end else begin
            spec_raw_c = op_eff_c[1] ? '0 : i_rs1;
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign accept_c = i_valid && o_ready && !i_flush;
    assign start_c  = accept_c && !special_c;

    logic                done_c;
    logic [2*XLEN-1:0]   acc_nxt_c;

    ysyx_22050710_md_iter #(
        .XLEN (XLEN),
        .CW   (CW)
    ) u_iter (
        .clk       (i_clk),
        .rst       (i_rst),
        .start     (start_c),
        .step      (state_q == S_CALC),
        .mode_div  (op_eff_c[2]),
        .n         (n_c),
        .a         (a_load_c),
        .b         (mag_b_c),
        .done_c    (done_c),
        .acc_nxt_c (acc_nxt_c)
    );

    logic [2*XLEN-1:0] prod_mag_c, prod_s_c;
    logic [XLEN-1:0]   quo_s_c, rem_s_c, calc_raw_c;

    // Sign correction and result selection on the final iteration's value.
    always_comb begin
        prod_mag_c = acc_nxt_c >> (word_q ? 32 : 0);
        prod_s_c   = neg_q ? -prod_mag_c : prod_mag_c;
        quo_s_c    = neg_q ? -acc_nxt_c[XLEN-1:0] : acc_nxt_c[XLEN-1:0];
        rem_s_c    = rneg_q ? -acc_nxt_c[2*XLEN-1:XLEN] : acc_nxt_c[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       calc_raw_c = prod_s_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_raw_c = prod_s_c[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              calc_raw_c = quo_s_c;
            OP_REM, OP_REMU:              calc_raw_c = rem_s_c;
            default:                      calc_raw_c = rem_s_c;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = special_c ? S_DONE : S_CALC;
            S_CALC:  if (done_c) state_d = S_DONE;
            S_DONE:  if (i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_flush) state_d = S_IDLE;
    end

    always_comb begin
        op_d    = op_q;
        word_d  = word_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        valid_d = (state_d == S_DONE);
        if (state_q == S_IDLE && accept_c) begin
            op_d   = op_eff_c;
            word_d = word_c;
            neg_d  = a_neg_c ^ b_neg_c;
            rneg_d = a_neg_c;
            if (special_c) res_d = fit(word_c, spec_raw_c);
        end
        if (state_q == S_CALC && done_c) res_d = fit(word_q, calc_raw_c);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q    <= OP_MUL;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            op_q    <= op_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_result = res_q;

endmodule

// File: tb/tb_ysyx_22050710_exu_md.sv
// Bench for ysyx_22050710_exu_md (XLEN=64): directed literal cases plus randomized traffic against an arithmetic model.
module tb_ysyx_22050710_exu_md;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_word, i_flush, i_ready;
    logic [2:0]  i_op;
    logic [63:0] i_rs1, i_rs2;
    logic        o_ready, o_valid;
    logic [63:0] o_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22050710_exu_md #(.XLEN(64), .WORD_OPS(1)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_word   (i_word),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural result of one M-extension instruction.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       pa, pb, p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] wa, wb;
        logic [63:0]        q, r;
        logic [31:0]        wq, wr;
        if (!op[2]) begin
            if (w) begin
                p = {96'd0, a[31:0]} * {96'd0, b[31:0]};
                return sx32(p[31:0]);
            end
            pa = (op == 3'b011) ? {64'd0, a} : {{64{a[63]}}, a};
            pb = op[1] ? {64'd0, b} : {{64{b[63]}}, b};
            p  = pa * pb;
            return (op == 3'b000) ? p[63:0] : p[127:64];
        end
        if (w) begin
            wa = a[31:0];
            wb = b[31:0];
            if (wb == 0) begin
                wq = '1; wr = wa;
            end else if (!op[0] && wa == 32'sh8000_0000 && wb == -32'sd1) begin
                wq = wa; wr = '0;
            end else if (!op[0]) begin
                wq = wa / wb; wr = wa % wb;
            end else begin
                wq = a[31:0] / b[31:0]; wr = a[31:0] % b[31:0];
            end
            return op[1] ? sx32(wr) : sx32(wq);
        end
        sa = a;
        sb = b;
        if (b == 0) begin
            q = '1; r = a;
        end else if (!op[0] && a == 64'h8000_0000_0000_0000 && sb == -64'sd1) begin
            q = a; r = '0;
        end else if (!op[0]) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // Cycles from accept to o_valid: one for the no-iteration divide cases, else N+1.
    function automatic int ref_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, an, bn, mn;
        mask = w ? 64'h0000_0000_FFFF_FFFF : '1;
        mn   = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        an   = a & mask;
        bn   = b & mask;
        if (op[2] && (bn == 0 || (!op[0] && an == mn && bn == mask))) return 1;
        return w ? 33 : 65;
    endfunction

    // Cycle-by-cycle compare of handshake outputs and result against the model.
    task automatic monitor();
        logic        pend;
        int          cyc, lat;
        logic [63:0] exp_res;
        pend = 1'b0; cyc = 0; lat = 0; exp_res = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                chk("rst_valid", 64'(o_valid), 64'd0);
                chk("rst_ready", 64'(o_ready), 64'd1);
                chk("rst_result", o_result, 64'd0);
            end else begin
                if (pend) cyc++;
                chk("mon_valid", 64'(o_valid), 64'(pend && cyc >= lat));
                chk("mon_ready", 64'(o_ready), 64'(!pend));
                if (o_valid && pend && cyc >= lat) chk("mon_result", o_result, exp_res);
                if (i_flush) begin
                    pend = 1'b0;
                end else if (pend && o_valid && i_ready) begin
                    pend = 1'b0;
                end else if (!pend && i_valid) begin
                    pend    = 1'b1;
                    cyc     = 0;
                    exp_res = ref_md(i_op, i_word, i_rs1, i_rs2);
                    lat     = ref_lat(i_op, i_word, i_rs1, i_rs2);
                end
            end
        end
    endtask

    // Called #2 after a rising edge with the unit idle; returns the same way after the result handshake.
    task automatic do_op(input string nm, input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat, input int stall);
        int c;
        i_valid = 1'b1; i_op = op; i_word = w; i_rs1 = a; i_rs2 = b;
        @(posedge clk); #2;
        i_valid = 1'b0;
        c = 1;
        while (!o_valid && c < 200) begin
            @(posedge clk); #2;
            c++;
        end
        chk({nm, "_lat"}, 64'(c), 64'(exp_lat));
        chk({nm, "_res"}, o_result, exp);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #2;
            chk({nm, "_hold_res"}, o_result, exp);
            chk({nm, "_hold_valid"}, 64'(o_valid), 64'd1);
            chk({nm, "_hold_ready"}, 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        @(posedge clk); #2;
        i_ready = 1'b0;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int seen;
        rst = 1'b1; i_valid = 1'b0; i_word = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_op = 3'b000; i_rs1 = '0; i_rs2 = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ready", 64'(o_ready), 64'd1);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_result", o_result, 64'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        do_op("mul_7_m3", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 3);
        do_op("mulhu_ones", 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        do_op("mulh_ones", 3'b001, 1'b0, '1, '1, 64'd0, 65, 0);
        do_op("mulhsu_m1_2", 3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        do_op("divu_by0", 3'b101, 1'b0, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        do_op("rem_by0", 3'b110, 1'b0, 64'd10, 64'd0, 64'd10, 1, 0);
        do_op("divw_by0", 3'b100, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        do_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
        do_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
        do_op("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0);
        do_op("divu_100_7", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);
        do_op("mulh_word", 3'b001, 1'b1, 64'h0000_0000_0001_8000, 64'h0000_0000_0001_0000,
              64'hFFFF_FFFF_8000_0000, 33, 0);
        do_op("divw_m7_2", 3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        do_op("remw_m7_2", 3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);

        // Flush during an iterating DIV: accepted at T, flush sampled at the end of T+10.
        i_valid = 1'b1; i_op = 3'b100; i_word = 1'b0; i_rs1 = 64'd1000; i_rs2 = 64'd7;
        @(posedge clk); #2;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        i_flush = 1'b1;
        @(posedge clk); #2;
        i_flush = 1'b0;
        chk("flush_ready", 64'(o_ready), 64'd1);
        chk("flush_valid", 64'(o_valid), 64'd0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #2;
            if (o_valid) seen++;
        end
        chk("flush_never_valid", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of an iteration.
        i_valid = 1'b1; i_op = 3'b000; i_rs1 = 64'd3; i_rs2 = 64'd5;
        @(posedge clk); #2;
        i_valid = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(o_valid), 64'd0);
        chk("async_rst_result", o_result, 64'd0);
        chk("async_rst_ready", 64'(o_ready), 64'd1);
        @(posedge clk); #2;
        rst = 1'b0;

        // Randomized traffic; every cycle is checked by the monitor.
        for (int k = 0; k < 8000; k++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_op    = 3'($urandom_range(0, 7));
            i_word  = ($urandom_range(0, 2) == 0);
            i_rs1   = pick();
            i_rs2   = pick();
            i_ready = ($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 199) == 0);
            @(posedge clk); #2;
        end
        i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        chk("drain_ready", 64'(o_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
